atanh_search: RTL and testbench

Inverse of the NAR-Net tanh activation: takes a signed Q1.7 activation value `y` and returns the signed Q1.7 pre-activation `x` whose tanh table entry best matches it. The search is an 8-step successive approximation over the existing negedge-clocked tanh table. It sits beside the activation stage and serves weight-update and debug paths that need to back-project stored activations. Input and output each use a valid/ready handshake.

---
 rtl/nar_act_pkg.sv | 41 ++++
 rtl/atanh_search_if.sv | 33 +++
 rtl/tanh_lut.sv | 29 ++
 rtl/atanh_search.sv | 125 ++++++++++++
 tb/tb_atanh_search.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/nar_act_pkg.sv
// Shared activation-stage definitions: Q1.7 format, tanh table range,
// search FSM states and the elaboration-time tanh generator.
package nar_act_pkg;

    localparam int ACT_N = 8;
    localparam int ACT_Q = 7;

    localparam logic signed [7:0] TANH_MIN = -8'sd97;
    localparam logic signed [7:0] TANH_MAX = 8'sd97;

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        DONE
    } state_t;

    // tanh(x / 2^q) scaled by 2^q, truncated toward zero; 2^60 fixed-point
    // series keeps near-integer entries (e.g. x = 1) on the correct side.
    function automatic logic [7:0] tanh_fx(input int x, input int unsigned q);
        logic [127:0] one;
        logic [127:0] z;
        logic [127:0] term;
        logic [127:0] e;
        logic [127:0] quo;
        logic [7:0]   mag;
        int unsigned  a;
        a    = (x < 0) ? int'(-x) : x;
        one  = 128'd1 << 60;
        z    = 128'(a) << (61 - q);
        term = one;
        e    = one;
        for (int unsigned n = 1; n < 48; n++) begin
            term = ((term * z) >> 60) / 128'(n);
            e    = e + term;
        end
        quo = ((e - one) << q) / (e + one);
        mag = quo[7:0];
        return (x < 0) ? (8'd0 - mag) : mag;
    endfunction

endpackage

// File: rtl/atanh_search_if.sv
// Input/output valid-ready bundle for atanh_search.
// out_sat exists only when ATANH_SEARCH_SAT_EN is defined.
interface atanh_search_if #(
    parameter int N = 8
);
    logic                in_valid;
    logic                in_ready;
    logic signed [N-1:0] y_in;
    logic                out_valid;
    logic                out_ready;
    logic        [N-1:0] x_out;
`ifdef ATANH_SEARCH_SAT_EN
    logic                out_sat;

    modport master (
        output in_valid, y_in, out_ready,
        input  in_ready, out_valid, x_out, out_sat
    );
    modport slave (
        input  in_valid, y_in, out_ready,
        output in_ready, out_valid, x_out, out_sat
    );
`else
    modport master (
        output in_valid, y_in, out_ready,
        input  in_ready, out_valid, x_out
    );
    modport slave (
        input  in_valid, y_in, out_ready,
        output in_ready, out_valid, x_out
    );
`endif
endinterface

// File: rtl/tanh_lut.sv
// Negedge-registered tanh table: addr is signed Q1.7 x, data is signed
// Q1.7 tanh(x), contents generated at elaboration.
module tanh_lut
    import nar_act_pkg::*;
#(
    parameter int N = ACT_N,
    parameter int Q = ACT_Q
) (
    input  logic                clk,
    input  logic        [N-1:0] addr,
    output logic signed [N-1:0] data
);

    logic signed [N-1:0] w_rom [2**N];
    logic signed [N-1:0] r_data;

    for (genvar g = 0; g < 2**N; g++) begin : g_rom
        localparam logic signed [N-1:0] L_VAL =
            N'(tanh_fx((g < 2**(N-1)) ? g : g - 2**N, Q));
        assign w_rom[g] = L_VAL;
    end

    always_ff @(negedge clk) begin
        r_data <= w_rom[addr];
    end

    assign data = r_data;

endmodule

// File: rtl/atanh_search.sv
// Inverse tanh by 8-step successive approximation over tanh_lut.
// Optional out_sat flag under ATANH_SEARCH_SAT_EN.
module atanh_search
    import nar_act_pkg::*;
#(
    parameter int N = ACT_N,
    parameter int Q = ACT_Q
) (
    input  logic         clk,
    input  logic         rst_n,
    atanh_search_if.slave bus
);

    localparam logic [N-1:0] MSB = {1'b1, {(N-1){1'b0}}};
    localparam logic [2:0]   K_TOP = 3'(N - 1);

    state_t              r_state, w_state_nx;
    logic signed [N-1:0] r_y, w_y_nx;
    logic signed [N-1:0] w_lut_data;
    logic        [N-1:0] r_u, w_u_nx;
    logic        [N-1:0] r_lut_addr, w_addr_nx;
    logic        [N-1:0] w_trial, w_u_upd;
    logic        [2:0]   r_k, w_k_nx;
    logic                r_probe, w_probe_nx;
    logic                w_hit;
`ifdef ATANH_SEARCH_SAT_EN
    logic                r_sat, w_sat_nx;
`endif

    tanh_lut #(
        .N(N),
        .Q(Q)
    ) u_lut (
        .clk  (clk),
        .addr (r_lut_addr),
        .data (w_lut_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_y        <= '0;
            r_u        <= '0;
            r_k        <= '0;
            r_probe    <= 1'b0;
            r_lut_addr <= '0;
`ifdef ATANH_SEARCH_SAT_EN
            r_sat      <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nx;
            r_y        <= w_y_nx;
            r_u        <= w_u_nx;
            r_k        <= w_k_nx;
            r_probe    <= w_probe_nx;
            r_lut_addr <= w_addr_nx;
`ifdef ATANH_SEARCH_SAT_EN
            r_sat      <= w_sat_nx;
`endif
        end
    end

    // r_probe low means the LUT address for bit r_k is not yet issued;
    // once issued, the next address is built from the just-decided u.
    always_comb begin
        w_state_nx = r_state;
        w_y_nx     = r_y;
        w_u_nx     = r_u;
        w_k_nx     = r_k;
        w_probe_nx = r_probe;
        w_addr_nx  = r_lut_addr;
`ifdef ATANH_SEARCH_SAT_EN
        w_sat_nx   = r_sat;
`endif
        w_trial    = r_u | (N'(1) << r_k);
        w_hit      = (w_lut_data <= r_y);
        w_u_upd    = w_hit ? w_trial : r_u;

        case (r_state)
            IDLE: begin
                if (bus.in_valid) begin
                    w_state_nx = SEARCH;
                    w_y_nx     = bus.y_in;
                    w_u_nx     = '0;
                    w_k_nx     = K_TOP;
                    w_probe_nx = 1'b0;
`ifdef ATANH_SEARCH_SAT_EN
                    w_sat_nx   = (bus.y_in < TANH_MIN) || (bus.y_in > TANH_MAX);
`endif
                end
            end
            SEARCH: begin
                if (!r_probe) begin
                    w_addr_nx  = w_trial ^ MSB;
                    w_probe_nx = 1'b1;
                end else begin
                    w_u_nx = w_u_upd;
                    if (r_k == '0) begin
                        w_state_nx = DONE;
                        w_probe_nx = 1'b0;
                    end else begin
                        w_k_nx    = r_k - 3'd1;
                        w_addr_nx = (w_u_upd | (N'(1) << (r_k - 3'd1))) ^ MSB;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    w_state_nx = IDLE;
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.x_out     = r_u ^ MSB;
`ifdef ATANH_SEARCH_SAT_EN
    assign bus.out_sat   = r_sat;
`endif

endmodule

// File: tb/tb_atanh_search.sv
// Directed bench for atanh_search: table-edge vectors, output back-pressure
// and mid-search reset; out_sat checks follow ATANH_SEARCH_SAT_EN.
module tb_atanh_search;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_fail;
    int   n_total;
    int   edges;

    atanh_search_if #(.N(8)) bus ();

    atanh_search #(
        .N(8),
        .Q(7)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present y for one accept edge, then scramble y_in to prove it is not re-sampled.
    task automatic accept(input string tag, input logic [7:0] y);
        @(negedge clk);
        bus.y_in     = y;
        bus.in_valid = 1'b1;
        check({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.y_in     = ~y;
    endtask

    task automatic wait_out(input string tag);
        edges = 0;
        while (!bus.out_valid && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check({tag, ".latency"}, 32'(edges), 32'd9);
    endtask

    task automatic expect_result(input string tag, input logic [7:0] x, input logic sat);
        check({tag, ".x_out"}, 32'(bus.x_out), 32'(x));
`ifdef ATANH_SEARCH_SAT_EN
        check({tag, ".out_sat"}, 32'(bus.out_sat), 32'(sat));
`endif
    endtask

    task automatic handshake(input string tag);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({tag, ".valid_drop"}, 32'(bus.out_valid), 32'd0);
        check({tag, ".ready_back"}, 32'(bus.in_ready), 32'd1);
    endtask

    task automatic vector(input string tag, input logic [7:0] y, input logic [7:0] x, input logic sat);
        accept(tag, y);
        wait_out(tag);
        expect_result(tag, x, sat);
        handshake(tag);
    endtask

    initial begin
        n_pass        = 0;
        n_fail        = 0;
        n_total       = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.y_in      = '0;
        bus.out_ready = 1'b0;
        #1;
        check("rst.out_valid", 32'(bus.out_valid), 32'd0);
        check("rst.in_ready", 32'(bus.in_ready), 32'd1);
        expect_result("rst", 8'h80, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        vector("y20", 8'h20, 8'h21, 1'b0);
        vector("y00", 8'h00, 8'h01, 1'b0);
        vector("y9F", 8'h9F, 8'h81, 1'b0);
        vector("y80", 8'h80, 8'h80, 1'b1);
        vector("y70", 8'h70, 8'h7F, 1'b1);
        vector("y61", 8'h61, 8'h7F, 1'b0);

        // Back-pressure: pending request must wait for the output handshake.
        accept("hold", 8'h20);
        wait_out("hold");
        expect_result("hold", 8'h21, 1'b0);
        @(negedge clk);
        bus.y_in     = 8'h00;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold.x_stable", 32'(bus.x_out), 32'h21);
            check("hold.valid_held", 32'(bus.out_valid), 32'd1);
            check("hold.in_ready_low", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("hold.hs_valid_drop", 32'(bus.out_valid), 32'd0);
        check("hold.hs_idle", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.y_in     = 8'h55;
        check("hold.next_accepted", 32'(bus.in_ready), 32'd0);
        wait_out("hold_next");
        expect_result("hold_next", 8'h01, 1'b0);
        handshake("hold_next");

        // Reset during the fourth search cycle discards the search.
        accept("rstmid", 8'h20);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid.out_valid", 32'(bus.out_valid), 32'd0);
        check("rstmid.in_ready", 32'(bus.in_ready), 32'd1);
        expect_result("rstmid", 8'h80, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        vector("after_rst", 8'h20, 8'h21, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
